// File: rtl/uart_reporter.sv
// Game-event reporter: buffers events, converts values to zero-padded ASCII decimal and sends <letter><digits>CR LF.
// Latency: first pulse 3 + up to DIGITS*10 cycles after accept; backpressure: evt_ready low only when the FIFO is full.

module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = out_rdy && !empty;
    assign do_push = in_vld && (!full || do_pop);
    assign out_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= in_dat;
    end
endmodule

module uart_reporter #(
    parameter int FIFO_DEPTH = 4,
    parameter int VALUE_W    = 16,
    parameter int DIGITS     = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               evt_valid,
    input  logic [2:0]         evt_code,
    input  logic [VALUE_W-1:0] evt_value,
    output logic               evt_ready,
    output logic               transmit,
    output logic [7:0]         tx_byte,
    input  logic               is_transmitting,
    output logic               busy,
    output logic [7:0]         drop_cnt
);
    function automatic longint unsigned pow10(input int e);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [7:0] letter_of(input logic [2:0] code);
        case (code)
            3'd0:    return 8'h53;
            3'd1:    return 8'h4C;
            3'd2:    return 8'h56;
            3'd3:    return 8'h47;
            3'd4:    return 8'h48;
            3'd5:    return 8'h50;
            3'd6:    return 8'h4E;
            default: return 8'h3F;
        endcase
    endfunction

    localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;
    localparam int CONV_W = $clog2(MAX_VAL + 1);
    localparam int REM_W  = (CONV_W > VALUE_W) ? CONV_W : VALUE_W;
    localparam int DPOS_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int IDX_W  = $clog2(DIGITS + 3);
    localparam logic [DPOS_W-1:0] LAST_DPOS = DPOS_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIGITS + 2);
    localparam logic [IDX_W-1:0]  CR_IDX    = IDX_W'(DIGITS + 1);
    localparam logic [IDX_W-1:0]  DIG_END   = IDX_W'(DIGITS);

    typedef struct packed {
        logic [2:0]         code;
        logic [VALUE_W-1:0] value;
    } evt_t;

    typedef enum logic [2:0] {
        IDLE, LOAD, CONV, ISSUE, WAIT_START, WAIT_DONE
    } state_t;

    state_t            state_q, state_n;
    evt_t              evt_in, head, ev_q;
    logic              fifo_full, fifo_empty, pop;
    logic [REM_W-1:0]  place_tbl [DIGITS];
    logic [REM_W-1:0]  place;
    logic [REM_W-1:0]  rem_q;
    logic [DPOS_W-1:0] dpos_q;
    logic [3:0]        dval_q;
    logic [7:0]        digit_q [DIGITS];
    logic [7:0]        letter_q;
    logic [IDX_W-1:0]  idx_q;
    logic [1:0]        guard_q;
    logic [7:0]        line_byte;
    logic              digit_done;

    assign evt_in = '{code: evt_code, value: evt_value};

    sync_fifo #(.W($bits(evt_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .in_vld  (evt_valid && evt_ready),
        .in_dat  (evt_in),
        .out_rdy (pop),
        .out_dat (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    for (genvar g = 0; g < DIGITS; g++) begin : g_place
        assign place_tbl[g] = REM_W'(pow10(DIGITS - 1 - g));
    end

    assign place      = place_tbl[dpos_q];
    assign digit_done = (rem_q < place);

    always_comb begin
        line_byte = letter_q;
        if (idx_q == '0)           line_byte = letter_q;
        else if (idx_q <= DIG_END) line_byte = digit_q[DPOS_W'(idx_q - 1'b1)];
        else if (idx_q == CR_IDX)  line_byte = 8'h0D;
        else                       line_byte = 8'h0A;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:       if (!fifo_empty) state_n = LOAD;
            LOAD:       state_n = CONV;
            CONV:       if (digit_done && dpos_q == LAST_DPOS) state_n = ISSUE;
            ISSUE:      if (!is_transmitting) state_n = WAIT_START;
            // Guard timeout keeps a missed busy edge from stalling the line.
            WAIT_START: if (is_transmitting || guard_q == 2'd3) state_n = WAIT_DONE;
            WAIT_DONE:  if (!is_transmitting) state_n = (idx_q == LAST_IDX) ? IDLE : ISSUE;
            default:    state_n = IDLE;
        endcase
    end

    always_comb begin
        evt_ready = !fifo_full;
        pop       = (state_q == IDLE) && !fifo_empty;
        transmit  = (state_q == WAIT_START) && (guard_q == 2'd0);
        busy      = (state_q != IDLE) || !fifo_empty;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ev_q     <= '0;
            letter_q <= '0;
            rem_q    <= '0;
            dpos_q   <= '0;
            dval_q   <= '0;
            idx_q    <= '0;
            guard_q  <= '0;
            tx_byte  <= '0;
            for (int i = 0; i < DIGITS; i++) digit_q[i] <= 8'h30;
        end else begin
            case (state_q)
                IDLE: if (!fifo_empty) ev_q <= head;
                LOAD: begin
                    letter_q <= letter_of(ev_q.code);
                    rem_q    <= (64'(ev_q.value) > MAX_VAL) ? REM_W'(MAX_VAL) : REM_W'(ev_q.value);
                    dpos_q   <= '0;
                    dval_q   <= '0;
                    idx_q    <= '0;
                end
                CONV: begin
                    if (!digit_done) begin
                        rem_q  <= rem_q - place;
                        dval_q <= dval_q + 1'b1;
                    end else begin
                        digit_q[dpos_q] <= 8'h30 + {4'd0, dval_q};
                        dval_q          <= '0;
                        if (dpos_q != LAST_DPOS) dpos_q <= dpos_q + 1'b1;
                    end
                end
                ISSUE: if (!is_transmitting) begin
                    tx_byte <= line_byte;
                    guard_q <= '0;
                end
                WAIT_START: if (guard_q != 2'd3) guard_q <= guard_q + 1'b1;
                WAIT_DONE:  if (!is_transmitting && idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                         drop_cnt <= '0;
        else if (evt_valid && !evt_ready && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
endmodule

// File: tb/tb_uart_reporter.sv
// Bench for uart_reporter: default instance (DIGITS=5) and a DIGITS=3 instance, each fed by a small uart model.
module tb_uart_reporter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  evt_valid;
    logic [1:0]  evt_ready;
    logic [1:0]  transmit;
    logic [1:0]  busy;
    logic [1:0]  is_tx = 2'b00;
    logic [2:0]  evt_code [2];
    logic [15:0] evt_value [2];
    logic [7:0]  tx_byte [2];
    logic [7:0]  drop_cnt [2];

    bit   [1:0]  stall = 2'b00;
    bit   [1:0]  never_mode = 2'b00;
    bit          chk_en = 1'b1;
    bit   [1:0]  prev_t = 2'b00;
    int          cnt [2] = '{0, 0};
    logic [7:0]  last_b [2] = '{8'h00, 8'h00};
    int          viol = 0;
    int          cyc = 0;
    logic [7:0]  rxq0 [$];
    logic [7:0]  rxq1 [$];
    int          pcyc0 [$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_reporter dut (
        .clk(clk), .reset(rst), .evt_valid(evt_valid[0]), .evt_code(evt_code[0]),
        .evt_value(evt_value[0]), .evt_ready(evt_ready[0]), .transmit(transmit[0]),
        .tx_byte(tx_byte[0]), .is_transmitting(is_tx[0]), .busy(busy[0]), .drop_cnt(drop_cnt[0])
    );

    uart_reporter #(.FIFO_DEPTH(4), .VALUE_W(16), .DIGITS(3)) dut3 (
        .clk(clk), .reset(rst), .evt_valid(evt_valid[1]), .evt_code(evt_code[1]),
        .evt_value(evt_value[1]), .evt_ready(evt_ready[1]), .transmit(transmit[1]),
        .tx_byte(tx_byte[1]), .is_transmitting(is_tx[1]), .busy(busy[1]), .drop_cnt(drop_cnt[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    // uart model: busy for 10 cycles per byte unless stalled or never raising busy
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (transmit[u] && (prev_t[u] || is_tx[u])) viol++;
            if (chk_en && is_tx[u] && !transmit[u] && tx_byte[u] !== last_b[u]) viol++;
            if (transmit[u]) begin
                last_b[u] = tx_byte[u];
                if (u == 0) begin
                    rxq0.push_back(tx_byte[0]);
                    pcyc0.push_back(cyc);
                end else begin
                    rxq1.push_back(tx_byte[1]);
                end
                cnt[u] = never_mode[u] ? 0 : 10;
            end else if (cnt[u] > 0) begin
                cnt[u] = cnt[u] - 1;
            end
            prev_t[u] = transmit[u];
            is_tx[u]  = stall[u] || (cnt[u] > 0);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int u, input logic [2:0] c, input logic [15:0] v);
        evt_code[u]  = c;
        evt_value[u] = v;
        evt_valid[u] = 1'b1;
        tick();
        evt_valid[u] = 1'b0;
    endtask

    task automatic wait_idle(input int u, input int budget, input string name);
        int n;
        n = 0;
        while (busy[u] && n < budget) begin
            tick();
            n++;
        end
        chk(name, 64'(busy[u]), 64'd0);
    endtask

    function automatic logic [63:0] get_line(input int u, input int s, input int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < n; i++) begin
            if (u == 0 && s + i < rxq0.size()) r = {r[55:0], rxq0[s+i]};
            else if (u == 1 && s + i < rxq1.size()) r = {r[55:0], rxq1[s+i]};
            else r = {r[55:0], 8'h00};
        end
        return r;
    endfunction

    typedef struct {
        int          u;
        logic [2:0]  code;
        logic [15:0] value;
        logic [63:0] exp;
        int          n;
        string       name;
    } vec_t;

    vec_t        vt [11];
    logic [63:0] exp4 [5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int s, acc, low, gap, min_gap, n;

        vt[0]  = '{0, 3'd0, 16'd123,   "S00123\r\n", 8, "s123"};
        vt[1]  = '{0, 3'd3, 16'd65535, "G65535\r\n", 8, "g65535"};
        vt[2]  = '{0, 3'd7, 16'd0,     "?00000\r\n", 8, "q0"};
        vt[3]  = '{0, 3'd1, 16'd42,    "L00042\r\n", 8, "l42"};
        vt[4]  = '{0, 3'd5, 16'd10000, "P10000\r\n", 8, "p10000"};
        vt[5]  = '{0, 3'd4, 16'd9,     "H00009\r\n", 8, "h9"};
        vt[6]  = '{0, 3'd6, 16'd50505, "N50505\r\n", 8, "n50505"};
        vt[7]  = '{1, 3'd0, 16'd1234,  "S999\r\n",   6, "d3_sat1234"};
        vt[8]  = '{1, 3'd2, 16'd1000,  "V999\r\n",   6, "d3_sat1000"};
        vt[9]  = '{1, 3'd1, 16'd999,   "L999\r\n",   6, "d3_999"};
        vt[10] = '{1, 3'd6, 16'd5,     "N005\r\n",   6, "d3_5"};
        exp4[0] = "S00007\r\n";
        exp4[1] = "L00107\r\n";
        exp4[2] = "V00207\r\n";
        exp4[3] = "G00307\r\n";
        exp4[4] = "H00407\r\n";

        rst = 1'b1;
        evt_valid = 2'b00;
        for (int u = 0; u < 2; u++) begin
            evt_code[u]  = 3'd0;
            evt_value[u] = 16'd0;
        end
        tick();
        tick();
        chk("rst_transmit", 64'(transmit[0]), 64'd0);
        chk("rst_tx_byte",  64'(tx_byte[0]), 64'd0);
        chk("rst_busy",     64'(busy[0]), 64'd0);
        chk("rst_drop",     64'(drop_cnt[0]), 64'd0);
        chk("rst_ready",    64'(evt_ready[0]), 64'd1);
        rst = 1'b0;
        tick();

        // table of single-line vectors on both instances
        for (int i = 0; i < 11; i++) begin
            s = (vt[i].u == 0) ? rxq0.size() : rxq1.size();
            push(vt[i].u, vt[i].code, vt[i].value);
            if (i == 0) chk("busy_after_push", 64'(busy[0]), 64'd1);
            wait_idle(vt[i].u, 2000, {vt[i].name, "_idle"});
            n = ((vt[i].u == 0) ? rxq0.size() : rxq1.size()) - s;
            chk({vt[i].name, "_bytes"}, 64'(n), 64'(vt[i].n));
            chk({vt[i].name, "_line"}, get_line(vt[i].u, s, vt[i].n), vt[i].exp);
        end

        // FIFO fill with the uart stalled
        stall[0] = 1'b1;
        tick();
        tick();
        s = rxq0.size();
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            evt_code[0]  = 3'(i);
            evt_value[0] = 16'(100 * i + 7);
            evt_valid[0] = 1'b1;
            if (evt_ready[0]) acc++;
            tick();
        end
        low = 0;
        evt_code[0]  = 3'd5;
        evt_value[0] = 16'd507;
        for (int j = 0; j < 3; j++) begin
            if (!evt_ready[0]) low++;
            tick();
        end
        evt_valid[0] = 1'b0;
        chk("fill_accepted", 64'(acc), 64'd5);
        chk("fill_ready_low", 64'(low), 64'd3);
        chk("fill_drop_cnt", 64'(drop_cnt[0]), 64'd3);
        stall[0] = 1'b0;
        wait_idle(0, 5000, "fill_idle");
        chk("fill_bytes", 64'(rxq0.size() - s), 64'd40);
        for (int i = 0; i < 5; i++) chk($sformatf("fill_line%0d", i), get_line(0, s + 8 * i, 8), exp4[i]);

        // uart that never raises busy: guard timeout drives the line out
        never_mode[0] = 1'b1;
        tick();
        s = pcyc0.size();
        push(0, 3'd0, 16'd77);
        wait_idle(0, 2000, "guard_idle");
        chk("guard_pulses", 64'(pcyc0.size() - s), 64'd8);
        min_gap = 1000;
        for (int i = s + 1; i < pcyc0.size(); i++) begin
            gap = pcyc0[i] - pcyc0[i-1];
            if (gap < min_gap) min_gap = gap;
        end
        chk("guard_gap_ge5", 64'(min_gap >= 5), 64'd1);
        chk("guard_line", get_line(0, s, 8), "S00077\r\n");
        never_mode[0] = 1'b0;
        tick();

        // reset in the middle of the third byte
        s = rxq0.size();
        push(0, 3'd2, 16'd321);
        n = 0;
        while (rxq0.size() < s + 3 && n < 2000) begin
            tick();
            n++;
        end
        chk("midrst_third_byte", 64'(rxq0.size() - s), 64'd3);
        chk_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_transmit", 64'(transmit[0]), 64'd0);
        chk("midrst_busy", 64'(busy[0]), 64'd0);
        chk("midrst_drop", 64'(drop_cnt[0]), 64'd0);
        chk("midrst_ready", 64'(evt_ready[0]), 64'd1);
        tick();
        rst = 1'b0;
        n = 0;
        while (is_tx[0] && n < 100) begin
            tick();
            n++;
        end
        chk_en = 1'b1;
        tick();
        s = rxq0.size();
        push(0, 3'd1, 16'd8);
        wait_idle(0, 2000, "postrst_idle");
        chk("postrst_line", get_line(0, s, 8), "L00008\r\n");
        chk("postrst_bytes", 64'(rxq0.size() - s), 64'd8);

        chk("protocol_violations", 64'(viol), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
